// File: rtl/mem_responder_pkg.sv
// Shared cache/memory protocol types plus the memory responder's constants and FSM encoding.
package cache_def;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

    localparam int MEM_LATENCY     = 4;
    localparam int MEM_DEPTH_LINES = 1024;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_type;

endpackage

// File: rtl/mem_line_ram.sv
// Line store: DEPTH_LINES x 128, single port, synchronous write, combinational read.
// Latency: write on the clock edge, read same cycle; no backpressure, contents are not reset.
module mem_line_ram #(
    parameter int DEPTH_LINES = 1024,
    parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [127:0]      wdata,
    output logic [127:0]      rdata
);

    logic [127:0] lines [DEPTH_LINES];

    always_ff @(posedge clk) begin
        if (we) begin
            lines[addr] <= wdata;
        end
    end

    assign rdata = lines[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory end of the cache-to-memory protocol: one request at a time, ready pulses LATENCY cycles after capture.
// No backpressure: requests arriving while BUSY/RESP are ignored; a valid seen in IDLE is a new request.
module mem_responder
    import cache_def::*;
#(
    parameter int LATENCY     = MEM_LATENCY,
    parameter int DEPTH_LINES = MEM_DEPTH_LINES
) (
    input  logic         clk,
    input  logic         rst,
    input  mem_req_type  mem_req,
    output mem_data_type mem_data
);

    localparam int         IDX_W    = $clog2(DEPTH_LINES);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    mem_state_type     state;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  lat_idx;
    logic [127:0]      lat_data;
    logic              lat_rw;
    mem_data_type      rsp_q;

    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  ram_addr;
    logic              ram_we;
    logic [127:0]      ram_wdata;
    logic [127:0]      ram_rdata;
    logic              unused_addr_bits;

    assign req_idx          = mem_req.addr[4 +: IDX_W];
    assign unused_addr_bits = ^{mem_req.addr[31:4+IDX_W], mem_req.addr[3:0]};

    // The write commits on the edge that enters RESP. With LATENCY=1 that edge is the
    // capture edge itself, so the live request drives the port instead of the latches.
    always_comb begin
        ram_addr  = lat_idx;
        ram_wdata = lat_data;
        ram_we    = 1'b0;
        if (state == IDLE) begin
            ram_addr  = req_idx;
            ram_wdata = mem_req.data;
            ram_we    = (LATENCY == 1) && mem_req.valid && mem_req.rw;
        end else if (state == BUSY) begin
            ram_we    = (cnt == 4'd1) && lat_rw;
        end
    end

    mem_line_ram #(
        .DEPTH_LINES (DEPTH_LINES),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            lat_idx  <= '0;
            lat_data <= '0;
            lat_rw   <= 1'b0;
            rsp_q    <= '0;
        end else begin
            rsp_q.ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req.valid) begin
                        lat_idx  <= req_idx;
                        lat_data <= mem_req.data;
                        lat_rw   <= mem_req.rw;
                        cnt      <= CNT_LOAD;
                        state    <= (LATENCY == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    // Line already holds the written data for writes, so one path serves both.
                    rsp_q.ready <= 1'b1;
                    rsp_q.data  <= ram_rdata;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_data = rsp_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a line-array reference model.
module tb_mem_responder;
    import cache_def::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    mem_req_type  mem_req;
    mem_data_type mem_data;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [127:0] model_mem [DEPTH];
    bit           known     [DEPTH];

    mem_responder #(.LATENCY(LAT), .DEPTH_LINES(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (mem_req),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 4) % DEPTH);
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Single request with a one-cycle valid pulse; returns cycles to ready and the data seen.
    task automatic issue(input logic [31:0] addr, input logic [127:0] data, input logic rw,
                         output int lat, output logic [127:0] rdata,
                         output logic ready_after, output logic [127:0] data_after);
        mem_req.addr  = addr;
        mem_req.data  = data;
        mem_req.rw    = rw;
        mem_req.valid = 1'b1;
        tick;
        mem_req.valid = 1'b0;
        mem_req.addr  = $urandom;
        mem_req.data  = rand_line();
        mem_req.rw    = 1'($urandom);
        lat = 0;
        while (mem_data.ready !== 1'b1 && lat < 40) begin
            tick;
            lat++;
        end
        rdata = mem_data.data;
        tick;
        ready_after = mem_data.ready;
        data_after  = mem_data.data;
        if (rw && lat < 40) begin
            model_mem[line_of(addr)] = data;
            known[line_of(addr)]     = 1'b1;
        end
    endtask

    task automatic test_reset;
        int lat; logic [127:0] rd; logic ra; logic [127:0] da;
        logic [127:0] d;
        mem_req = '0;
        rst = 1'b1;
        repeat (3) tick;
        tests_run++;
        if (mem_data.ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ready: got %b want 0", mem_data.ready);
        end
        tests_run++;
        if (mem_data.data !== 128'd0) begin
            tests_failed++; $display("FAIL reset_data: got %h want 0", mem_data.data);
        end
        rst = 1'b0;
        d = rand_line();
        issue(32'h0000_0070, d, 1'b1, lat, rd, ra, da);
        tests_run++;
        if (lat !== LAT) begin
            tests_failed++; $display("FAIL first_edge_latency: got %0d want %0d", lat, LAT);
        end
        tests_run++;
        if (rd !== d) begin
            tests_failed++; $display("FAIL first_edge_echo: got %h want %h", rd, d);
        end
    endtask

    task automatic test_write_read;
        int lat; logic [127:0] rd; logic ra; logic [127:0] da;
        logic [127:0] d = 128'h0123456789ABCDEF0123456789ABCDEF;
        issue(32'h0000_0010, d, 1'b1, lat, rd, ra, da);
        tests_run++;
        if (lat !== LAT || rd !== d) begin
            tests_failed++; $display("FAIL write_echo: got lat %0d data %h want lat %0d data %h", lat, rd, LAT, d);
        end
        issue(32'h0000_0010, rand_line(), 1'b0, lat, rd, ra, da);
        tests_run++;
        if (lat !== LAT || rd !== d) begin
            tests_failed++; $display("FAIL read_after_write: got lat %0d data %h want lat %0d data %h", lat, rd, LAT, d);
        end
    endtask

    task automatic test_latency;
        logic         r [1:5];
        logic [127:0] dd [1:5];
        logic [127:0] exp = model_mem[line_of(32'h0000_0010)];
        mem_req.addr  = 32'h0000_0010;
        mem_req.data  = rand_line();
        mem_req.rw    = 1'b0;
        mem_req.valid = 1'b1;
        tick;
        mem_req.valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick;
            r[i]  = mem_data.ready;
            dd[i] = mem_data.data;
        end
        for (int i = 1; i <= 5; i++) begin
            tests_run++;
            if (r[i] !== (i == LAT)) begin
                tests_failed++; $display("FAIL latency_ready_N+%0d: got %b want %b", i, r[i], (i == LAT));
            end
        end
        tests_run++;
        if (dd[4] !== exp || dd[5] !== exp) begin
            tests_failed++; $display("FAIL latency_data_hold: got %h then %h want %h", dd[4], dd[5], exp);
        end
    endtask

    task automatic test_midflight;
        int lat; logic [127:0] rd; logic ra; logic [127:0] da;
        logic [31:0]  a  = 32'h0000_1230;
        logic [31:0]  b  = 32'h0000_0300;
        logic [127:0] e0 = rand_line();
        logic [127:0] d  = rand_line();
        logic [127:0] e1 = ~e0;
        issue(b, e0, 1'b1, lat, rd, ra, da);
        mem_req.addr  = a;
        mem_req.data  = d;
        mem_req.rw    = 1'b1;
        mem_req.valid = 1'b1;
        tick;
        mem_req.valid = 1'b0;
        tick;
        tick;
        mem_req.addr  = b;
        mem_req.data  = e1;
        mem_req.valid = 1'b1;
        lat = 2;
        while (mem_data.ready !== 1'b1 && lat < 40) begin
            tick;
            lat++;
        end
        mem_req.valid = 1'b0;
        rd = mem_data.data;
        model_mem[line_of(a)] = d;
        known[line_of(a)]     = 1'b1;
        tests_run++;
        if (lat !== LAT || rd !== d) begin
            tests_failed++; $display("FAIL midflight_resp: got lat %0d data %h want lat %0d data %h", lat, rd, LAT, d);
        end
        tick;
        tests_run++;
        if (mem_data.ready !== 1'b0) begin
            tests_failed++; $display("FAIL midflight_single_pulse: got %b want 0", mem_data.ready);
        end
        issue(b, rand_line(), 1'b0, lat, rd, ra, da);
        tests_run++;
        if (rd !== e0) begin
            tests_failed++; $display("FAIL midflight_new_addr_untouched: got %h want %h", rd, e0);
        end
        issue(a, rand_line(), 1'b0, lat, rd, ra, da);
        tests_run++;
        if (rd !== d) begin
            tests_failed++; $display("FAIL midflight_latched_addr: got %h want %h", rd, d);
        end
    endtask

    task automatic test_reset_abort;
        int lat; logic [127:0] rd; logic ra; logic [127:0] da;
        logic saw_ready = 1'b0;
        logic [127:0] pre = {4{32'h5555_5555}};
        issue(32'h0000_0050, pre, 1'b1, lat, rd, ra, da);
        mem_req.addr  = 32'h0000_0050;
        mem_req.data  = {4{32'hAAAA_AAAA}};
        mem_req.rw    = 1'b1;
        mem_req.valid = 1'b1;
        tick;
        mem_req.valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        #1;
        tests_run++;
        if (mem_data.ready !== 1'b0 || mem_data.data !== 128'd0) begin
            tests_failed++; $display("FAIL abort_async_clear: got ready %b data %h want 0/0", mem_data.ready, mem_data.data);
        end
        repeat (3) tick;
        rst = 1'b0;
        repeat (8) begin
            tick;
            if (mem_data.ready === 1'b1) saw_ready = 1'b1;
        end
        tests_run++;
        if (saw_ready !== 1'b0) begin
            tests_failed++; $display("FAIL abort_no_ready: got ready pulse want none");
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        issue(32'h0000_0050, rand_line(), 1'b0, lat, rd, ra, da);
        tests_run++;
        if (lat !== LAT || rd !== pre) begin
            tests_failed++; $display("FAIL abort_not_committed: got lat %0d data %h want lat %0d data %h", lat, rd, LAT, pre);
        end
    endtask

    task automatic test_alias;
        int lat; logic [127:0] rd; logic ra; logic [127:0] da;
        logic [127:0] d = {4{32'hDEAD_BEEF}};
        issue(32'h0000_0020, d, 1'b1, lat, rd, ra, da);
        issue(32'h0000_4020, rand_line(), 1'b0, lat, rd, ra, da);
        tests_run++;
        if (lat !== LAT || rd !== d) begin
            tests_failed++; $display("FAIL alias_4020: got lat %0d data %h want %h", lat, rd, d);
        end
        issue(32'hFFFF_C02F, rand_line(), 1'b0, lat, rd, ra, da);
        tests_run++;
        if (rd !== d) begin
            tests_failed++; $display("FAIL alias_upper_lower: got %h want %h", rd, d);
        end
    endtask

    task automatic test_back_to_back;
        mem_req_type  reqs [3];
        logic [127:0] exp  [3];
        int           t_rdy [3];
        int           seen = 0;
        int           t = 0;
        logic [31:0]  a0 = {18'($urandom), 10'd600, 4'($urandom)};
        logic [31:0]  a1 = {18'($urandom), 10'd601, 4'($urandom)};
        reqs[0] = '{addr: a0, data: rand_line(), rw: 1'b1, valid: 1'b1};
        reqs[1] = '{addr: a0, data: rand_line(), rw: 1'b0, valid: 1'b1};
        reqs[2] = '{addr: a1, data: rand_line(), rw: 1'b1, valid: 1'b1};
        exp[0] = reqs[0].data;
        exp[1] = reqs[0].data;
        exp[2] = reqs[2].data;
        mem_req = reqs[0];
        tick;
        while (seen < 3 && t < 60) begin
            if (mem_data.ready === 1'b1) begin
                t_rdy[seen] = t;
                tests_run++;
                if (mem_data.data !== exp[seen]) begin
                    tests_failed++; $display("FAIL b2b_data_%0d: got %h want %h", seen, mem_data.data, exp[seen]);
                end
                if (reqs[seen].rw) begin
                    model_mem[line_of(reqs[seen].addr)] = reqs[seen].data;
                    known[line_of(reqs[seen].addr)]     = 1'b1;
                end
                seen++;
                if (seen < 3) mem_req = reqs[seen];
                else          mem_req.valid = 1'b0;
            end
            tick;
            t++;
        end
        mem_req.valid = 1'b0;
        tests_run++;
        if (seen !== 3) begin
            tests_failed++; $display("FAIL b2b_count: got %0d pulses want 3", seen);
        end else begin
            tests_run++;
            if (t_rdy[0] !== LAT || t_rdy[1] - t_rdy[0] !== LAT + 1 || t_rdy[2] - t_rdy[1] !== LAT + 1) begin
                tests_failed++; $display("FAIL b2b_spacing: got %0d,%0d,%0d want %0d,%0d,%0d",
                    t_rdy[0], t_rdy[1], t_rdy[2], LAT, 2*LAT+1, 3*LAT+2);
            end
        end
        tick;
    endtask

    task automatic test_random;
        int lat; logic [127:0] rd; logic ra; logic [127:0] da;
        int pool [8];
        for (int i = 0; i < 8; i++) pool[i] = int'($urandom_range(DEPTH - 1, 0));
        for (int n = 0; n < 40; n++) begin
            int           ln = pool[$urandom_range(7, 0)];
            logic [31:0]  a  = $urandom;
            logic         rw = 1'($urandom);
            logic [127:0] d  = rand_line();
            logic [127:0] exp;
            a[13:4] = 10'(ln);
            if (!known[ln]) rw = 1'b1;
            exp = rw ? d : model_mem[ln];
            issue(a, d, rw, lat, rd, ra, da);
            tests_run++;
            if (lat !== LAT || rd !== exp) begin
                tests_failed++; $display("FAIL random_%0d: got lat %0d data %h want lat %0d data %h", n, lat, rd, LAT, exp);
            end
            tests_run++;
            if (ra !== 1'b0 || da !== rd) begin
                tests_failed++; $display("FAIL random_hold_%0d: got ready %b data %h want 0 and %h", n, ra, da, rd);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        test_reset;
        test_write_read;
        test_latency;
        test_midflight;
        test_reset_abort;
        test_alias;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request capture to mem_data.ready (legal range 1..15).
REQ-002 SHALL have parameter DEPTH_LINES, default 1024, meaning number of 128-bit lines stored (power of two).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_req  input  mem_req_type  cache-to-memory request (addr, data[127:0], rw, valid).
REQ-006 SHALL have port mem_data  output  mem_data_type  memory-to-cache response (data[127:0], ready).

Function
REQ-007 SHALL implement the memory end of the cache-to-memory protocol: line index = mem_req.addr[4 +: log2(DEPTH_LINES)]; addr[3:0] and upper bits ignored (aliasing wraps modulo DEPTH_LINES).
REQ-008 SHALL use FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-009 IDLE: if mem_req.valid=1 at an edge, SHALL latch addr, data, rw into internal registers, load the latency counter with LATENCY-1, and go to BUSY (LATENCY>1) or RESP (LATENCY=1).
REQ-010 BUSY: SHALL decrement the counter each edge; at count 0 SHALL go to RESP; changes on mem_req during BUSY/RESP SHALL be ignored.
REQ-011 RESP: mem_data.ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-012 ready SHALL rise exactly LATENCY cycles after the capture edge; back-to-back requests SHALL yield one response per LATENCY+1 cycles.
REQ-013 Read (rw=0): mem_data.data SHALL equal the stored line at the latched index while ready=1.
REQ-014 Write (rw=1): the latched 128-bit data SHALL be committed to the latched index on the edge entering RESP; mem_data.data SHALL echo the written line while ready=1.
REQ-015 mem_data.data SHALL hold its last value when ready=0.
REQ-016 Requester rule: valid SHALL be deasserted or replaced by a new request in the cycle after ready; a valid still high in IDLE is treated as a new request.
REQ-017 Read following a write to the same index SHALL return the written data (no forwarding hazard, since the write commits before IDLE).
REQ-018 Counter width SHALL be 4 bits; no arithmetic wrap is reachable within the legal LATENCY range.

Reset
REQ-019 Asserting rst SHALL immediately force state IDLE, counter 0, mem_data.ready=0, and mem_data.data=0.
REQ-020 Reset during BUSY SHALL abort the request; a pending write SHALL NOT be committed, and no ready SHALL follow.
REQ-021 Line storage SHALL NOT be reset; its contents after power-up are undefined.
REQ-022 The first request SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-023 Constants MEM_LATENCY (4) and MEM_DEPTH_LINES (1024) and the enum mem_state_type {IDLE, BUSY, RESP} SHALL be added to package cache_def.
REQ-024 The existing cache_def types mem_req_type and mem_data_type SHALL be reused unchanged.
REQ-025 Storage SHALL be a sub-module mem_line_ram: single-port, synchronous write, asynchronous read, DEPTH_LINES x 128.
REQ-026 The FSM, counter and latched request registers SHALL reside in mem_responder.

Verification
REQ-027 Write then read: write addr 0x0000_0010 with data 0x0123..CDEF, then read the same address -> ready at +4 cycles each, and the read returns 0x0123..CDEF.
REQ-028 Latency: read request captured at cycle N -> ready=1 only at N+4 and for exactly 1 cycle, with ready=0 at N+1..N+3 and at N+5.
REQ-029 Mid-flight change: change addr and data 2 cycles after capture -> the response uses the latched values, and the memory is unchanged at the new addr.
REQ-030 Reset abort: rst asserted 2 cycles after capture of a write of 0xAAAA.. to index 5 -> ready never rises, and a later read of index 5 returns a value other than 0xAAAA.. (preloaded 0x5555..).
REQ-031 Aliasing: write 0xDEAD.. to addr 0x0000_0020, then read addr 0x0000_4020 (DEPTH 1024) -> returns 0xDEAD...
REQ-032 Back-to-back: valid held high across 3 requests -> three ready pulses spaced 5 cycles apart.
